i2c_target_wr: RTL

Write-only I2C target (responder) that takes the synchronous `scl_in`/`sda_in` from the chip's SDA/SCL pads and drives the SDA pad's `going_out` level. It decodes START/STOP, matches the 7-bit device address and ACKs each byte. It turns each data byte into a one-cycle register-write strobe for the synthesizer control registers. It is the receiving end of the off-chip host's I2C writes and sits between the bidirectional pad cells and the synth register file.

---
 rtl/i2c_pkg.sv | 20 ++
 rtl/i2c_sync_edge.sv | 60 ++++++
 rtl/i2c_target_wr.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/i2c_pkg.sv
// Shared types and constants for the write-only I2C target.
package i2c_pkg;

  localparam int I2C_ADDR_W   = 7;
  localparam int I2C_BYTE_W   = 8;
  localparam int I2C_FILT_LEN = 3;

  // Protocol position of the target within one bus transaction.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_REG,
    ST_REG_ACK,
    ST_DATA,
    ST_DATA_ACK,
    ST_IGNORE
  } i2c_tgt_state_t;

endpackage

// File: rtl/i2c_sync_edge.sv
// Two-flop synchronizer for one I2C pad line, with an optional stability
// filter (I2C_TGT_GLITCH_FILTER_EN) and registered rise/fall event pulses.
// level, rise and fall all update on the same clock, so the events and the
// level seen by the consumer always agree.
module i2c_sync_edge
  import i2c_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic line_in,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [1:0] sync_q;
  logic       sync_bit;
  logic       take_hi;
  logic       take_lo;

  // Metastability guard; resets to 1 because an idle I2C line is high.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= 2'b11;
    else        sync_q <= {sync_q[0], line_in};
  end

  assign sync_bit = sync_q[1];

`ifdef I2C_TGT_GLITCH_FILTER_EN
  logic [I2C_FILT_LEN-2:0] hist_q;

  // Sample history: the level may only move once all recent samples agree.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hist_q <= '1;
    else        hist_q <= {hist_q[I2C_FILT_LEN-3:0], sync_bit};
  end

  assign take_hi = sync_bit & (&hist_q);
  assign take_lo = ~sync_bit & ~(|hist_q);
`else
  assign take_hi = sync_bit;
  assign take_lo = ~sync_bit;
`endif

  // Conditioned level plus one-cycle edge events derived from it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level <= 1'b1;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      rise <= take_hi & ~level;
      fall <= take_lo & level;
      if (take_hi)      level <= 1'b1;
      else if (take_lo) level <= 1'b0;
    end
  end

endmodule

// File: rtl/i2c_target_wr.sv
// Write-only I2C target: decodes START/STOP, matches DEV_ADDR (write only),
// ACKs each byte and emits a one-cycle register write per data byte with an
// auto-incrementing register pointer. Optional input glitch filter is
// enabled by defining I2C_TGT_GLITCH_FILTER_EN.
module i2c_target_wr
  import i2c_pkg::*;
#(
  parameter logic [I2C_ADDR_W-1:0] DEV_ADDR = 7'h2A
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  scl_in,
  input  logic                  sda_in,
  output logic                  sda_out,
  output logic                  wr_en,
  output logic [I2C_BYTE_W-1:0] wr_addr,
  output logic [I2C_BYTE_W-1:0] wr_data,
  output logic                  busy
);

  logic scl_lvl, scl_rise, scl_fall;
  logic sda_lvl, sda_rise, sda_fall;
  logic start_det, stop_det;

  i2c_sync_edge u_scl (
    .clk    (clk),
    .rst_n  (rst_n),
    .line_in(scl_in),
    .level  (scl_lvl),
    .rise   (scl_rise),
    .fall   (scl_fall)
  );

  i2c_sync_edge u_sda (
    .clk    (clk),
    .rst_n  (rst_n),
    .line_in(sda_in),
    .level  (sda_lvl),
    .rise   (sda_rise),
    .fall   (sda_fall)
  );

  // SDA may only move while SCL is low, except for START and STOP.
  assign start_det = sda_fall & scl_lvl;
  assign stop_det  = sda_rise & scl_lvl;

  i2c_tgt_state_t        state_q, state_d;
  logic [2:0]            bit_cnt_q, bit_cnt_d;
  logic                  byte_full_q, byte_full_d;
  logic [I2C_BYTE_W-1:0] shreg_q, shreg_d;
  logic [I2C_BYTE_W-1:0] ptr_q, ptr_d;
  logic                  sda_out_d, wr_en_d, busy_d;
  logic [I2C_BYTE_W-1:0] wr_addr_d, wr_data_d;
  logic                  rx_state, byte_done;

  // State, datapath and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      byte_full_q <= 1'b0;
      shreg_q     <= '0;
      ptr_q       <= '0;
      sda_out     <= 1'b1;
      wr_en       <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
      busy        <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      byte_full_q <= byte_full_d;
      shreg_q     <= shreg_d;
      ptr_q       <= ptr_d;
      sda_out     <= sda_out_d;
      wr_en       <= wr_en_d;
      wr_addr     <= wr_addr_d;
      wr_data     <= wr_data_d;
      busy        <= busy_d;
    end
  end

  assign rx_state  = state_q inside {ST_ADDR, ST_REG, ST_DATA};
  // A byte is finished on the SCL fall that closes its eighth bit.
  assign byte_done = scl_fall & byte_full_q;

  // Next-state and output decode; STOP outranks START, both outrank bit traffic.
  always_comb begin
    // NOTE: every signal gets a default first so no path can infer a latch.
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    byte_full_d = byte_full_q;
    shreg_d     = shreg_q;
    ptr_d       = ptr_q;
    sda_out_d   = sda_out;
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr;
    wr_data_d   = wr_data;
    busy_d      = busy;

    if (stop_det) begin
      state_d     = ST_IDLE;
      sda_out_d   = 1'b1;
      busy_d      = 1'b0;
      bit_cnt_d   = '0;
      byte_full_d = 1'b0;
    end else if (start_det) begin
      // Also a repeated START: any partial byte is dropped.
      state_d     = ST_ADDR;
      sda_out_d   = 1'b1;
      bit_cnt_d   = '0;
      byte_full_d = 1'b0;
    end else begin
      if (rx_state && scl_rise && !byte_full_q) begin
        shreg_d   = {shreg_q[I2C_BYTE_W-2:0], sda_lvl};
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) byte_full_d = 1'b1;
      end

      unique case (state_q)
        ST_ADDR: begin
          if (byte_done) begin
            byte_full_d = 1'b0;
            if (shreg_q == {DEV_ADDR, 1'b0}) begin
              state_d   = ST_ADDR_ACK;
              sda_out_d = 1'b0;
              busy_d    = 1'b1;
            end else begin
              // Foreign address or a read: stay off the bus until START/STOP.
              state_d = ST_IGNORE;
              busy_d  = 1'b0;
            end
          end
        end
        ST_REG: begin
          if (byte_done) begin
            byte_full_d = 1'b0;
            ptr_d       = shreg_q;
            state_d     = ST_REG_ACK;
            sda_out_d   = 1'b0;
          end
        end
        ST_DATA: begin
          if (byte_done) begin
            byte_full_d = 1'b0;
            wr_en_d     = 1'b1;
            wr_addr_d   = ptr_q;
            wr_data_d   = shreg_q;
            ptr_d       = ptr_q + 8'd1;
            state_d     = ST_DATA_ACK;
            sda_out_d   = 1'b0;
          end
        end
        ST_ADDR_ACK: if (scl_fall) begin sda_out_d = 1'b1; state_d = ST_REG;  end
        ST_REG_ACK:  if (scl_fall) begin sda_out_d = 1'b1; state_d = ST_DATA; end
        ST_DATA_ACK: if (scl_fall) begin sda_out_d = 1'b1; state_d = ST_DATA; end
        default: sda_out_d = 1'b1;
      endcase
    end
  end

endmodule
